// File: rtl/div_unit.sv
// ---------------------------------------------------------------------------
// div_unit : multi-cycle radix-2 restoring divider for the EX stage (DIV/DIVU)
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               hold,
  input  logic               cancel,
  output logic               stall_div,
  output logic               done,
  output logic [2*WIDTH-1:0] result
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] rem, quo, b_mag;
  logic [CNT_W-1:0] cnt;
  logic             q_neg, r_neg;

  logic             accept, last_step;
  logic [WIDTH-1:0] a_mag, b_in_mag;
  logic [WIDTH:0]   shifted, diff;
  logic [WIDTH-1:0] rem_step, quo_step, rem_fix, quo_fix;

  always_comb begin
    accept    = (state == IDLE) && start && !cancel;
    last_step = (cnt == CNT_W'(WIDTH - 1));
    a_mag     = (signed_div && a[WIDTH-1]) ? -a : a;
    b_in_mag  = (signed_div && b[WIDTH-1]) ? -b : b;

    // Trial subtraction on the 33-bit window; a borrow means restore.
    shifted = {rem, quo[WIDTH-1]};
    diff    = shifted - {1'b0, b_mag};
    if (!diff[WIDTH]) begin
      rem_step = diff[WIDTH-1:0];
      quo_step = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_step = shifted[WIDTH-1:0];
      quo_step = {quo[WIDTH-2:0], 1'b0};
    end
    rem_fix = r_neg ? -rem_step : rem_step;
    quo_fix = q_neg ? -quo_step : quo_step;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    stall_div  = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        stall_div = accept;
        if (accept) state_next = (b == '0) ? FINISH : CALC;
      end
      CALC: begin
        stall_div = 1'b1;
        if (last_step) state_next = FINISH;
      end
      FINISH: begin
        done = 1'b1;
        if (!hold) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (cancel) state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem    <= '0;
      quo    <= '0;
      b_mag  <= '0;
      cnt    <= '0;
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
      result <= '0;
    end else if (!cancel) begin
      case (state)
        IDLE: begin
          if (accept) begin
            b_mag <= b_in_mag;
            q_neg <= (a[WIDTH-1] ^ b[WIDTH-1]) & signed_div;
            r_neg <= a[WIDTH-1] & signed_div;
            rem   <= '0;
            quo   <= a_mag;
            cnt   <= '0;
            if (b == '0) result <= {a, {WIDTH{1'b1}}};
          end
        end
        CALC: begin
          rem <= rem_step;
          quo <= quo_step;
          cnt <= cnt + 1'b1;
          if (last_step) result <= {rem_fix, quo_fix};
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_div_unit.sv
// ---------------------------------------------------------------------------
// tb_div_unit : directed bench for div_unit with a transaction-level reference
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_div_unit;

  logic        clk, rst, start, signed_div, hold, cancel;
  logic [31:0] a, b;
  logic        stall_div, done;
  logic [63:0] result;

  int n_cmp = 0;
  int n_bad = 0;
  bit checking = 0;

  div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_div(signed_div),
    .a(a), .b(b), .hold(hold), .cancel(cancel),
    .stall_div(stall_div), .done(done), .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: architectural quotient/remainder from 64-bit signed arithmetic.
  function automatic logic [63:0] model_div(input logic [31:0] x, input logic [31:0] y, input logic sd);
    longint sx, sy, q, r;
    if (y == 32'd0) return {x, 32'hFFFF_FFFF};
    sx = sd ? longint'($signed(x)) : longint'({32'd0, x});
    sy = sd ? longint'($signed(y)) : longint'({32'd0, y});
    q = sx / sy;
    r = sx % sy;
    return {r[31:0], q[31:0]};
  endfunction

  // Transaction timing model: 0 = free, 1 = busy for m_left edges, 2 = presenting.
  int          m_phase = 0;
  int          m_left  = 0;
  logic [63:0] m_result  = '0;
  logic [63:0] m_pending = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase  = 0;
      m_result = '0;
    end else if (cancel) begin
      m_phase = 0;
    end else begin
      case (m_phase)
        0: if (start) begin
          m_pending = model_div(a, b, signed_div);
          if (b == 32'd0) begin
            m_result = m_pending;
            m_phase  = 2;
          end else begin
            m_left  = 32;
            m_phase = 1;
          end
        end
        1: begin
          m_left--;
          if (m_left == 0) begin
            m_result = m_pending;
            m_phase  = 2;
          end
        end
        default: if (!hold) m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      check("stall_div", {63'd0, stall_div},
            {63'd0, ((m_phase == 0) && start && !cancel) || (m_phase == 1)});
      check("done", {63'd0, done}, {63'd0, m_phase == 2});
      check("result", result, m_result);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one division, wait for done, pin latency and result, return to IDLE.
  task automatic run_div(input logic [31:0] x, input logic [31:0] y, input logic sd,
                         input logic [63:0] exp_res, input int exp_lat);
    int n;
    a = x; b = y; signed_div = sd; start = 1'b1;
    step();
    start = 1'b0; a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D; signed_div = ~sd;
    n = 1;
    while (!done && n < 40) begin
      step();
      n++;
    end
    check("latency", 64'(n), 64'(exp_lat));
    check("literal_result", result, exp_res);
    step();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; signed_div = 1'b0; hold = 1'b0; cancel = 1'b0;
    a = '0; b = '0;
    step();
    step();
    rst = 1'b0;
    checking = 1;
    check("reset_result", result, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_stall", {63'd0, stall_div}, 64'd0);

    run_div(32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 33);
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
    run_div(32'd7, 32'hFFFF_FFFE, 1'b1, {32'd1, 32'hFFFF_FFFD}, 33);
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'd0, 32'h8000_0000}, 33);
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, {32'h8000_0000, 32'd0}, 33);
    run_div(32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, {32'hFFFF_FFFE, 32'd14}, 33);
    run_div(32'hFFFF_FFFF, 32'd1, 1'b0, {32'd0, 32'hFFFF_FFFF}, 33);

    // Divide by zero: stall only in the request cycle, done right after.
    a = 32'h1234; b = 32'd0; signed_div = 1'b0; start = 1'b1;
    #1 check("dz_stall_req", {63'd0, stall_div}, 64'd1);
    step();
    start = 1'b0;
    check("dz_done", {63'd0, done}, 64'd1);
    check("dz_stall_done", {63'd0, stall_div}, 64'd0);
    check("dz_result", result, {32'h1234, 32'hFFFF_FFFF});
    step();
    run_div(32'hFFFF_FF00, 32'd0, 1'b1, {32'hFFFF_FF00, 32'hFFFF_FFFF}, 1);

    // Hold keeps the finished result presented and blocks new requests.
    hold = 1'b1;
    a = 32'd1000; b = 32'd10; signed_div = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    repeat (32) step();
    check("hold_done", {63'd0, done}, 64'd1);
    a = 32'd9; b = 32'd3; start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold_stable_done", {63'd0, done}, 64'd1);
      check("hold_stable_result", result, {32'd0, 32'd100});
      check("hold_no_stall", {63'd0, stall_div}, 64'd0);
    end
    hold = 1'b0; start = 1'b0;
    step();
    check("hold_release_done", {63'd0, done}, 64'd0);
    run_div(32'd9, 32'd3, 1'b0, {32'd0, 32'd3}, 33);

    // Cancel at cycle 10 of a running divide.
    a = 32'hFFFF_FFFF; b = 32'd3; signed_div = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    repeat (9) step();
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    check("cancel_done", {63'd0, done}, 64'd0);
    check("cancel_stall", {63'd0, stall_div}, 64'd0);
    check("cancel_result", result, {32'd0, 32'd3});
    step();
    run_div(32'd50, 32'd5, 1'b0, {32'd0, 32'd10}, 33);

    // Cancel beats start in the same cycle.
    a = 32'd8; b = 32'd2; start = 1'b1; cancel = 1'b1;
    #1 check("cancel_vs_start_stall", {63'd0, stall_div}, 64'd0);
    step();
    start = 1'b0; cancel = 1'b0;
    check("cancel_vs_start_idle", {63'd0, stall_div}, 64'd0);
    step();

    // Reset at cycle 20 of a running divide.
    a = 32'd12345; b = 32'd67; signed_div = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    repeat (19) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_mid_result", result, 64'd0);
    check("rst_mid_done", {63'd0, done}, 64'd0);
    check("rst_mid_stall", {63'd0, stall_div}, 64'd0);
    run_div(32'd12345, 32'd67, 1'b0, {32'd17, 32'd184}, 33);

    repeat (2) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
